fixed_mult_pipe: RTL
====================

// Module: fixed_mult_pipe
// PURPOSE
//  Pipelined signed fixed-point multiplier (Q INT_BITS.FRAC_BITS) for the Julia worker
//  iteration datapath (z^2 + c terms). Generalises the combinational 20-bit Q10.10 multiply:
//  - parametrised format and pipeline depth
//  - selectable rounding and saturating overflow
//  - valid/ready handshake with full-pipeline backpressure
// PARAMETERS
//  INT_BITS    10  integer bits incl. sign; W = INT_BITS+FRAC_BITS
//  FRAC_BITS   10  fractional bits (>=1)
//  STAGES      3   register stages accept->result (>=2)
//  ROUND_MODE  0   0 = truncate (floor, arithmetic shift); 1 = round half up (+2^(FRAC_BITS-1))
//  SATURATE    1   1 = clamp to max/min on overflow; 0 = wrap (low W bits)
// PORTS
//  clk        in   1  clock, rising edge
//  n_rst      in   1  asynchronous active-low reset
//  in_valid   in   1  a/b valid
//  in_ready   out  1  block accepts a/b this cycle
//  a          in   W  signed multiplicand, Q format
//  b          in   W  signed multiplier, Q format
//  out_valid  out  1  result/overflow valid
//  out_ready  in   1  consumer accepts result this cycle
//  result     out  W  signed product, Q format
//  overflow   out  1  product not representable in W bits; qualified by out_valid
// BEHAVIOUR
//  - Reset (async, n_rst=0): all stage valid bits, data registers, result, overflow,
//    out_valid -> 0 immediately; in-flight operations discarded; no output after release.
//  - advance = !out_valid || out_ready; in_ready = advance (combinational).
//  - Accept when in_valid && in_ready. All stages shift together when advance=1, else all hold.
//  - Bubbles are not collapsed.
//  - Latency: exactly STAGES cycles accept->out_valid when out_ready held high; throughput 1/clk.
//  - Results emerge in acceptance order. Output held stable while out_valid && !out_ready.
//  - Arithmetic:
//    - p = a*b, full 2W-bit signed.
//    - ROUND_MODE=1: add 2^(FRAC_BITS-1) in 2W+1 bits.
//    - s = p >>> FRAC_BITS (arithmetic).
//    - overflow = bits of s above bit W-1 not all equal to s[W-1].
//    - overflow & SATURATE=1: result = s<0 ? 1<<(W-1) : (1<<(W-1))-1.
//    - overflow & SATURATE=0: result = s[W-1:0].
//    - otherwise result = s[W-1:0]; overflow is flagged in both modes.
//  - Stage split:
//    - stage 1 registers a/b;
//    - middle stages: multiply, with retiming freedom if STAGES>3;
//    - last stage: round/shift/saturate, registers result+overflow.
//  - Simultaneous in_valid and out_ready with a full pipe: the output pops and the input is
//    accepted in the same cycle.
// TESTING (W=20, FRAC=10, STAGES=3, out_ready=1 unless noted)
//  1 a=b=20'hFFB33 (-1.2), ROUND=0 -> result 20'h005C3, overflow 0, 3 cycles after accept
//  2 a=b=20'h00400 (1.0) -> 20'h00400; back-to-back stream of 8 pairs -> 8 results on 8 consecutive cycles
//  3 rounding: a=20'h00001,b=20'h00200 -> 0 (ROUND=0) / 1 (ROUND=1);
//    a=20'hFFFFF,b=20'h00200 -> 20'hFFFFF (ROUND=0) / 0 (ROUND=1)
//  4 a=b=20'h7FC00 (511.0) -> SAT=1: 20'h7FFFF, ov=1;
//    a=20'h7FC00,b=20'hFF800 (-2.0) -> 20'h80000, ov=1; SAT=0: low 20 bits, ov=1
//  5 out_ready=0 for 6 cycles while driving 5 pairs -> in_ready falls once 3 are held,
//    result stable; on release all 5 delivered in order, none lost or duplicated
//  6 n_rst pulsed low with 2 ops in flight -> out_valid/result/overflow 0 same cycle,
//    no output after release; next op completes normally

Source files
------------

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier (Q INT_BITS.FRAC_BITS) with optional
// round-half-up, optional saturation and a valid/ready handshake in which the
// whole pipe stalls together under backpressure.
module fixed_mult_pipe #(
    parameter int unsigned INT_BITS   = 10,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned ROUND_MODE = 0,
    parameter int unsigned SATURATE   = 1,
    localparam int unsigned W = INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow
);

    localparam int unsigned PW    = 2 * W;
    localparam int unsigned RW    = PW + 1;
    localparam int unsigned NPROD = STAGES - 2;
    localparam int unsigned HW    = RW - W + 1;

    localparam logic [RW-1:0] RND_ADD = (ROUND_MODE != 0) ? (RW'(1) << (FRAC_BITS - 1)) : '0;
    localparam logic [W-1:0]  MAX_POS = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W - 1){1'b0}}};

    logic                 advance;
    logic                 in_v_q;
    logic signed [W-1:0]  a_q;
    logic signed [W-1:0]  b_q;
    logic [NPROD-1:0]     prod_v_q;
    logic signed [PW-1:0] prod_q [NPROD];

    logic signed [RW-1:0] rnd_c;
    logic signed [RW-1:0] shf_c;
    logic [HW-1:0]        hi_c;
    logic                 ovf_c;
    logic [W-1:0]         res_c;

    // All stages move together only when the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operand capture stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (advance) begin
            in_v_q <= in_valid;
            a_q    <= a;
            b_q    <= b;
        end
    end

    // Full-width product followed by retiming stages when STAGES > 3.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prod_v_q <= '0;
            for (int i = 0; i < int'(NPROD); i++) begin
                prod_q[i] <= '0;
            end
        end else if (advance) begin
            prod_v_q[0] <= in_v_q;
            prod_q[0]   <= PW'(a_q) * PW'(b_q);
            for (int i = 1; i < int'(NPROD); i++) begin
                prod_v_q[i] <= prod_v_q[i-1];
                prod_q[i]   <= prod_q[i-1];
            end
        end
    end

    // Round, rescale to Q format, detect overflow and optionally clamp.
    always_comb begin
        rnd_c = RW'(prod_q[NPROD-1]) + RND_ADD;
        shf_c = rnd_c >>> FRAC_BITS;
        hi_c  = shf_c[RW-1:W-1];
        ovf_c = !((&hi_c) || !(|hi_c));
        res_c = shf_c[W-1:0];
        if (ovf_c && (SATURATE != 0)) begin
            res_c = shf_c[RW-1] ? MIN_NEG : MAX_POS;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= prod_v_q[NPROD-1];
            result    <= res_c;
            overflow  <= ovf_c;
        end
    end

endmodule
